// File: rtl/scpu_pkg.sv
// Shared types and constants for the SCPU instruction-fetch slice.
// Fetch-stage state encoding, MIPS opcode constants and the default reset PC.
package scpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] sign_extend16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/scpu_npc.sv
// Next-PC selection for the SCPU fetch stage: jump, taken branch or sequential.
// Jump wins over branch; every add wraps modulo 2^32.
module scpu_npc (
    input  logic [31:0] pc_plus4,
    input  logic [25:0] target,
    input  logic [31:0] imm32,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = {pc_plus4[31:28], target, 2'b00};
        end else if (Branch && zero) begin
            next_pc = pc_plus4 + (imm32 << 2);
        end
    end

endmodule

// File: rtl/scpu_ifetch.sv
// SCPU instruction-fetch stage: PC, req/ready fetch, instruction register and field decode.
// Optional fetch timeout with sticky fetch_err is enabled by defining SCPU_IFETCH_TIMEOUT_EN.
module scpu_ifetch
    import scpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [7:0]  TIMEOUT_CYC = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        zero,
    output logic        inst_valid,
    output logic [5:0]  OPcode,
    output logic [5:0]  Fun,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm32,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    state_t      state;
    logic [31:0] ir;
    logic [31:0] next_pc;

`ifdef SCPU_IFETCH_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;
`endif

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign OPcode    = ir[31:26];
    assign rs        = ir[25:21];
    assign rt        = ir[20:16];
    assign rd        = ir[15:11];
    assign Fun       = ir[5:0];
    assign imm32     = sign_extend16(ir[15:0]);

    scpu_npc u_npc (
        .pc_plus4 (pc_plus4),
        .target   (ir[25:0]),
        .imm32    (imm32),
        .Branch   (Branch),
        .Jump     (Jump),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    // imem_req and inst_valid are registered alongside the state so they switch with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir         <= NOP_INST;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
`ifdef SCPU_IFETCH_TIMEOUT_EN
            wait_cnt   <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
`ifdef SCPU_IFETCH_TIMEOUT_EN
                    wait_cnt <= 8'd0;
`endif
                end
                FETCH: begin
                    if (imem_ready) begin
                        ir         <= imem_rdata;
                        state      <= EXEC;
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b1;
                    end
`ifdef SCPU_IFETCH_TIMEOUT_EN
                    else if (wait_cnt + 8'd1 == TIMEOUT_CYC) begin
                        err_q      <= 1'b1;
                        ir         <= NOP_INST;
                        state      <= EXEC;
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                EXEC: begin
                    if (!stall) begin
                        pc         <= next_pc;
                        state      <= FETCH;
                        imem_req   <= 1'b1;
                        inst_valid <= 1'b0;
`ifdef SCPU_IFETCH_TIMEOUT_EN
                        wait_cnt   <= 8'd0;
`endif
                    end
                end
                default: begin
                    state      <= IDLE;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCPU_IFETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_scpu_ifetch.sv
// Directed self-checking bench for scpu_ifetch: decode, branch, jump, stall, wrap, wait and async reset.
// With SCPU_IFETCH_TIMEOUT_EN defined the DUT uses a 4-cycle timeout and the wait step expects it.
module tb_scpu_ifetch;

`ifdef SCPU_IFETCH_TIMEOUT_EN
    localparam logic [7:0] TB_TIMEOUT = 8'd4;
`else
    localparam logic [7:0] TB_TIMEOUT = 8'd255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        Branch;
    logic        Jump;
    logic        zero;
    logic        inst_valid;
    logic [5:0]  OPcode;
    logic [5:0]  Fun;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm32;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    scpu_ifetch #(
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .stall      (stall),
        .Branch     (Branch),
        .Jump       (Jump),
        .zero       (zero),
        .inst_valid (inst_valid),
        .OPcode     (OPcode),
        .Fun        (Fun),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm32      (imm32),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word with ready high for a single edge; the DUT must be in FETCH.
    task automatic fetch_word(input logic [31:0] word);
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic retire(input logic b, input logic j, input logic z);
        Branch = b;
        Jump   = j;
        zero   = z;
        stall  = 1'b0;
        step();
        Branch = 1'b0;
        Jump   = 1'b0;
        zero   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        zero       = 1'b0;
        #12;

        check("rst_req", imem_req, 1'b0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_opcode", OPcode, 6'h0);
        check("rst_imm32", imm32, 32'h0);
        check("rst_fetch_err", fetch_err, 1'b0);

        rst_n = 1'b1;
        #1;
        check("idle_req", imem_req, 1'b0);
        step();
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);

        // R-type add $10,$8,$9
        fetch_word(32'h0109_5020);
        check("add_valid", inst_valid, 1'b1);
        check("add_req", imem_req, 1'b0);
        check("add_opcode", OPcode, 6'h00);
        check("add_fun", Fun, 6'h20);
        check("add_rs", rs, 5'd8);
        check("add_rt", rt, 5'd9);
        check("add_rd", rd, 5'd10);
        check("add_imm32", imm32, 32'h0000_5020);
        retire(1'b0, 1'b0, 1'b0);
        check("seq_addr", imem_addr, 32'h4);
        check("seq_req", imem_req, 1'b1);
        check("seq_valid", inst_valid, 1'b0);

        fetch_word(32'h0000_0000);
        retire(1'b0, 1'b0, 1'b0);
        check("pc8_addr", imem_addr, 32'h8);

        // beq with offset -1 at pc 8: taken target is 8 itself
        fetch_word(32'h1000_FFFF);
        check("beq_opcode", OPcode, 6'h04);
        check("beq_imm32", imm32, 32'hFFFF_FFFF);
        retire(1'b1, 1'b0, 1'b1);
        check("beq_taken_addr", imem_addr, 32'h8);
        fetch_word(32'h1000_FFFF);
        retire(1'b1, 1'b0, 1'b0);
        check("beq_not_taken_addr", imem_addr, 32'hC);

        // beq offset -5 at pc C: 0x10 - 0x14 wraps to FFFF_FFFC
        fetch_word(32'h1000_FFFB);
        retire(1'b1, 1'b0, 1'b1);
        check("beq_wrap_addr", imem_addr, 32'hFFFF_FFFC);

        fetch_word(32'h0000_0000);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        stall      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'hFFFF_FFFC);
            check("stall_fun", Fun, 6'h0);
            check("stall_valid", inst_valid, 1'b1);
            check("stall_req", imem_req, 1'b0);
        end
        imem_ready = 1'b0;
        retire(1'b0, 1'b0, 1'b0);
        check("wrap_addr", imem_addr, 32'h0);

        // Jump takes priority over a taken branch
        fetch_word(32'h0BFF_FFFF);
        check("j_opcode", OPcode, 6'h02);
        retire(1'b1, 1'b1, 1'b1);
        check("j_prio_addr", imem_addr, 32'h0FFF_FFFC);
        fetch_word(32'h0000_0000);
        retire(1'b0, 1'b0, 1'b0);
        check("cross_addr", imem_addr, 32'h1000_0000);
        fetch_word(32'h0800_0010);
        retire(1'b0, 1'b1, 1'b0);
        check("jump_addr", imem_addr, 32'h1000_0040);

`ifdef SCPU_IFETCH_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_req", imem_req, 1'b1);
            check("wait_addr", imem_addr, 32'h1000_0040);
            check("wait_err", fetch_err, 1'b0);
        end
        step();
        check("timeout_err", fetch_err, 1'b1);
        check("timeout_valid", inst_valid, 1'b1);
        check("timeout_opcode", OPcode, 6'h0);
        check("timeout_fun", Fun, 6'h0);
        retire(1'b0, 1'b0, 1'b0);
        check("timeout_sticky", fetch_err, 1'b1);
`else
        for (int i = 0; i < 5; i++) begin
            step();
            check("wait_req", imem_req, 1'b1);
            check("wait_addr", imem_addr, 32'h1000_0040);
            check("wait_valid", inst_valid, 1'b0);
        end
        fetch_word(32'h8C00_0000);
        check("lw_opcode", OPcode, 6'h23);
        check("lw_valid", inst_valid, 1'b1);
        check("no_timeout_err", fetch_err, 1'b0);
        retire(1'b0, 1'b0, 1'b0);
`endif
        check("after_wait_addr", imem_addr, 32'h1000_0044);
        check("after_wait_req", imem_req, 1'b1);

        // Async reset in the middle of a pending fetch
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req", imem_req, 1'b0);
        check("async_pc", pc, 32'h0);
        check("async_opcode", OPcode, 6'h0);
        check("async_err", fetch_err, 1'b0);
        imem_ready = 1'b1;
        imem_rdata = 32'h8C00_0000;
        step();
        check("held_req", imem_req, 1'b0);
        check("held_valid", inst_valid, 1'b0);
        rst_n = 1'b1;
        #1;
        check("release_idle_req", imem_req, 1'b0);
        imem_ready = 1'b0;
        step();
        check("release_req", imem_req, 1'b1);
        check("release_addr", imem_addr, 32'h0);
        check("release_valid", inst_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
